alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Registered decode stage that drives the ALU's operand and control inputs. It accepts a fetched RV32I instruction with its PC and register-file read data, produces the ALU A/B operands, the 4-bit ALU control code, a branch flag and an illegal-instruction flag, and presents them through a valid/ready output. It sits between register read and the ALU. A two-entry skid buffer keeps `in_ready` free of any combinational path from `out_ready`.

## Interface
- `XLEN`, 32: data and address width; only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  stage can accept a beat; equals `!skid_valid && !rst`.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  PC of the instruction.
- `in_rs1_data`  in  32  rs1 read data.
- `in_rs2_data`  in  32  rs2 read data.
- `out_valid`  out  1  output beat present.
- `out_ready`  in  1  consumer accepts the beat.
- `out_alu_a`  out  32  ALU operand A.
- `out_alu_b`  out  32  ALU operand B.
- `out_alu_ctrl`  out  4  ALU control code, using the `define.v` encoding.
- `out_branch`  out  1  conditional branch; the ALU result is the taken flag.
- `out_illegal`  out  1  unsupported or illegal encoding.

## Operation
- ALU control codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, EQ=10, NEQ=11, GE=12, GEU=13.
- OP (0110011):
  - A=rs1, B=rs2; the control code comes from funct3.
  - funct7=0100000 is legal only with funct3 000 (SUB) and 101 (SRA).
  - Any funct7 other than 0000000 or 0100000 is illegal.
- OP-IMM (0010011):
  - A=rs1, B=sign-extended I-immediate.
  - SLLI requires funct7=0000000; otherwise illegal.
  - SRLI/SRAI are selected by funct7 0000000 / 0100000; other funct7 values are illegal.
  - For shifts, B=zero-extended shamt[4:0].
- BRANCH (1100011):
  - A=rs1, B=rs2, `branch`=1.
  - funct3 mapping: 000→EQ, 001→NEQ, 100→SLT, 101→GE, 110→SLTU, 111→GEU.
  - funct3 010 and 011 are illegal.
- LOAD (0000011): ADD, A=rs1, B=sign-extended I-immediate.
- STORE (0100011): ADD, A=rs1, B=sign-extended S-immediate.
- LUI: ADD, A=0, B={imm[31:12],12'b0}.
- AUIPC: ADD, A=pc, B={imm[31:12],12'b0}.
- JAL/JALR: ADD, A=pc, B=4 (link value).
- Any other opcode, or instr[1:0]≠11, is illegal.
- Illegal beats still pass through the stage with `illegal`=1, ctrl=ADD, A=0, B=0, `branch`=0.
- Skid buffer:
  - The main register drives the outputs; a second skid register catches one beat while the output is stalled.
  - Accept when `in_valid && in_ready`. The decode is computed combinationally from the inputs and written into a register.
  - Main register empty, or draining this cycle: the accepted beat loads main.
  - Main register full and not draining: the accepted beat loads skid.
  - Output drain (`out_valid && out_ready`) with skid full: main←skid and skid empties. A new input cannot arrive that cycle because `in_ready`=0.
  - Beat order is preserved; no beat is dropped or duplicated.

## Timing
- Reset (one cycle of `rst`=1):
  - `out_valid`=0; skid empty.
  - All data outputs = 0; `out_alu_ctrl`=0.
  - `in_ready`=0 while `rst` is high and 1 on the first cycle after.
- Latency: one cycle from acceptance to `out_valid`=1.
- Throughput: one beat per cycle while `out_ready`=1.
- While `out_valid && !out_ready`, all `out_*` signals hold stable.
- `in_ready` falls the cycle after the skid register fills. It rises the cycle after the skid register empties.
- `rst` asserted mid-stall flushes both entries; no stale beat appears after reset.
- Simultaneous accept and drain with skid empty: the new beat replaces main; `out_valid` stays 1.

## Test plan
- `add` 0x002081B3, rs1=5, rs2=7 → next cycle: `out_valid`=1, ctrl=0, A=5, B=7, `branch`=0, `illegal`=0.
- `sub` 0x402081B3 → ctrl=1. `addi` 0xFFF00093 → ctrl=0, B=0xFFFFFFFF. `srai` 0x4050D093 → ctrl=7, B=5.
- `bge` 0x0020D463, rs1=3, rs2=9 → ctrl=12, `branch`=1, A=3, B=9. `lui` 0x123452B7 → A=0, B=0x12345000.
- 0x0000000B (custom-0) and 0x0200D0B3 (funct7=0000001) → `illegal`=1, ctrl=0, A=B=0.
- Hold `out_ready`=0 with `in_valid`=1 and a stream of distinct beats:
  - Exactly 2 beats are accepted, then `in_ready`=0 and the outputs stay stable.
  - Raise `out_ready` → the beats drain in order with no gaps, loss or duplication.
  - Randomised `out_ready` over 1000 beats is checked against a scoreboard.
- Assert `rst` for one cycle while both entries are full → next cycle `out_valid`=0 and `in_ready`=1; the following beat emerges alone.

Source files
------------

// File: rtl/alu_decode_stage_if.sv
// Handshake and data bundle between register read, the decode stage and the ALU.
// The slave modport is the decode stage's view; master is the surrounding pipeline's view.
interface alu_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_alu_a;
  logic [XLEN-1:0] out_alu_b;
  logic [3:0]      out_alu_ctrl;
  logic            out_branch;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_alu_a, out_alu_b, out_alu_ctrl, out_branch, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_alu_a, out_alu_b, out_alu_ctrl, out_branch, out_illegal
  );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I decode stage producing ALU operands/control, registered behind a two-entry skid
// buffer so in_ready depends only on local state and reset, never on out_ready.
module alu_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  alu_decode_stage_if.slave  bus
);

  localparam logic [3:0] CTRL_ADD  = 4'd0;
  localparam logic [3:0] CTRL_SUB  = 4'd1;
  localparam logic [3:0] CTRL_SLL  = 4'd2;
  localparam logic [3:0] CTRL_SLT  = 4'd3;
  localparam logic [3:0] CTRL_SLTU = 4'd4;
  localparam logic [3:0] CTRL_XOR  = 4'd5;
  localparam logic [3:0] CTRL_SRL  = 4'd6;
  localparam logic [3:0] CTRL_SRA  = 4'd7;
  localparam logic [3:0] CTRL_OR   = 4'd8;
  localparam logic [3:0] CTRL_AND  = 4'd9;
  localparam logic [3:0] CTRL_EQ   = 4'd10;
  localparam logic [3:0] CTRL_NEQ  = 4'd11;
  localparam logic [3:0] CTRL_GE   = 4'd12;
  localparam logic [3:0] CTRL_GEU  = 4'd13;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctrl;
    logic            branch;
    logic            illegal;
  } beat_t;

  // funct3 -> ALU op for the base (funct7=0) register and immediate forms.
  function automatic logic [3:0] base_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000:  return CTRL_ADD;
      3'b001:  return CTRL_SLL;
      3'b010:  return CTRL_SLT;
      3'b011:  return CTRL_SLTU;
      3'b100:  return CTRL_XOR;
      3'b101:  return CTRL_SRL;
      3'b110:  return CTRL_OR;
      default: return CTRL_AND;
    endcase
  endfunction

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = XLEN'(instr[24:20]);

  beat_t decoded;
  logic  bad;

  always_comb begin
    decoded = '0;
    bad     = 1'b0;
    case (opcode)
      OPC_OP: begin
        decoded.a = bus.in_rs1_data;
        decoded.b = bus.in_rs2_data;
        if (funct7 == F7_BASE)
          decoded.ctrl = base_ctrl(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000)
          decoded.ctrl = CTRL_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101)
          decoded.ctrl = CTRL_SRA;
        else
          bad = 1'b1;
      end
      OPC_OP_IMM: begin
        decoded.a = bus.in_rs1_data;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          decoded.b = shamt;
          if (funct7 == F7_BASE)
            decoded.ctrl = base_ctrl(funct3);
          else if (funct7 == F7_ALT && funct3 == 3'b101)
            decoded.ctrl = CTRL_SRA;
          else
            bad = 1'b1;
        end else begin
          decoded.b    = imm_i;
          decoded.ctrl = base_ctrl(funct3);
        end
      end
      OPC_BRANCH: begin
        decoded.a      = bus.in_rs1_data;
        decoded.b      = bus.in_rs2_data;
        decoded.branch = 1'b1;
        case (funct3)
          3'b000:  decoded.ctrl = CTRL_EQ;
          3'b001:  decoded.ctrl = CTRL_NEQ;
          3'b100:  decoded.ctrl = CTRL_SLT;
          3'b101:  decoded.ctrl = CTRL_GE;
          3'b110:  decoded.ctrl = CTRL_SLTU;
          3'b111:  decoded.ctrl = CTRL_GEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        decoded.a = bus.in_rs1_data;
        decoded.b = imm_i;
      end
      OPC_STORE: begin
        decoded.a = bus.in_rs1_data;
        decoded.b = imm_s;
      end
      OPC_LUI: begin
        decoded.b = imm_u;
      end
      OPC_AUIPC: begin
        decoded.a = bus.in_pc;
        decoded.b = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        decoded.a = bus.in_pc;
        decoded.b = XLEN'(4);
      end
      default: bad = 1'b1;
    endcase
    // Illegal beats still flow through, but with neutral operands so the ALU sees nothing stale.
    if (bad) begin
      decoded         = '0;
      decoded.illegal = 1'b1;
    end
  end

  beat_t main_reg;
  beat_t skid_reg;
  logic  main_valid_reg;
  logic  skid_valid_reg;
  logic  in_ready_int;
  logic  accept;
  logic  drain;

  assign in_ready_int = !skid_valid_reg && !rst;
  assign accept       = bus.in_valid && in_ready_int;
  assign drain        = main_valid_reg && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      // A full skid blocks acceptance, so promoting it never races a new beat.
      if (drain && skid_valid_reg) begin
        main_reg       <= skid_reg;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        if (!main_valid_reg || drain) begin
          main_reg       <= decoded;
          main_valid_reg <= 1'b1;
        end else begin
          skid_reg       <= decoded;
          skid_valid_reg <= 1'b1;
        end
      end else if (drain) begin
        main_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = in_ready_int;
  assign bus.out_valid    = main_valid_reg;
  assign bus.out_alu_a    = main_reg.a;
  assign bus.out_alu_b    = main_reg.b;
  assign bus.out_alu_ctrl = main_reg.ctrl;
  assign bus.out_branch   = main_reg.branch;
  assign bus.out_illegal  = main_reg.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed vector table, stall/reset sequences, and a randomised
// stream checked against a queue-based model of the stage.
module tb_alu_decode_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        br;
    logic        ill;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        br;
    logic        ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_decode_stage_if #(.XLEN(32)) bus();
  alu_decode_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];

  // Reference decode from the ISA rules, table-driven by funct3.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
    int   f3 = int'(ins[14:12]);
    int   f7 = int'(ins[31:25]);
    int   op_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int   br_tab[8] = '{10, 11, -1, -1, 3, 12, 4, 13};
    logic [31:0] iimm = 32'($signed(ins[31:20]));
    logic [31:0] simm = 32'($signed({ins[31:25], ins[11:7]}));
    logic [31:0] uimm = ins & 32'hFFFF_F000;
    exp_t e = '0;
    bit   ok = 1;
    case (ins[6:0])
      7'h33: begin
        e.a = r1; e.b = r2;
        if (f7 == 0) e.ctrl = 4'(op_tab[f3]);
        else if (f7 == 32 && f3 == 0) e.ctrl = 4'd1;
        else if (f7 == 32 && f3 == 5) e.ctrl = 4'd7;
        else ok = 0;
      end
      7'h13: begin
        e.a = r1;
        if (f3 == 1 || f3 == 5) begin
          e.b = 32'(ins[24:20]);
          if (f7 == 0) e.ctrl = 4'(op_tab[f3]);
          else if (f7 == 32 && f3 == 5) e.ctrl = 4'd7;
          else ok = 0;
        end else begin
          e.b = iimm; e.ctrl = 4'(op_tab[f3]);
        end
      end
      7'h63: begin
        e.a = r1; e.b = r2; e.br = 1'b1;
        if (br_tab[f3] < 0) ok = 0; else e.ctrl = 4'(br_tab[f3]);
      end
      7'h03: begin e.a = r1; e.b = iimm; end
      7'h23: begin e.a = r1; e.b = simm; end
      7'h37: begin e.a = 0;  e.b = uimm; end
      7'h17: begin e.a = pc; e.b = uimm; end
      7'h6F, 7'h67: begin e.a = pc; e.b = 32'd4; end
      default: ok = 0;
    endcase
    if (!ok) begin
      e = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom();
    logic [6:0]  opcs[11] = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h0B, 7'h73};
    int sel = $urandom_range(0, 11);
    if (sel < 11) w[6:0] = opcs[sel];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk({tag, " alu_a"},   bus.out_alu_a,           q[0].a);
      chk({tag, " alu_b"},   bus.out_alu_b,           q[0].b);
      chk({tag, " ctrl"},    32'(bus.out_alu_ctrl),   32'(q[0].ctrl));
      chk({tag, " branch"},  32'(bus.out_branch),     32'(q[0].br));
      chk({tag, " illegal"}, 32'(bus.out_illegal),    32'(q[0].ill));
    end
  endtask

  // One clock: drive at negedge, check in_ready, advance the model at posedge, check outputs.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2, input logic ordy,
                      output logic acc);
    logic drn;
    bus.in_valid    = v;
    bus.in_instr    = ins;
    bus.in_pc       = pc;
    bus.in_rs1_data = r1;
    bus.in_rs2_data = r2;
    bus.out_ready   = ordy;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    @(posedge clk);
    acc = v && (q.size() < 2);
    drn = ordy && (q.size() > 0);
    if (drn) void'(q.pop_front());
    if (acc) q.push_back(model(ins, pc, r1, r2));
    @(negedge clk);
    check_out("step");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst in_ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst out_valid", 32'(bus.out_valid),    32'd0);
    chk("rst alu_a",     bus.out_alu_a,         32'd0);
    chk("rst alu_b",     bus.out_alu_b,         32'd0);
    chk("rst ctrl",      32'(bus.out_alu_ctrl), 32'd0);
    chk("rst branch",    32'(bus.out_branch),   32'd0);
    chk("rst illegal",   32'(bus.out_illegal),  32'd0);
    chk("rst in_ready",  32'(bus.in_ready),     32'd1);
  endtask

  vec_t vecs[15];

  initial begin
    logic        acc;
    int          n;
    int          cyc;
    logic [31:0] cur_ins, cur_pc, cur_r1, cur_r2;
    logic        cur_v;

    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_instr    = '0;
    bus.in_pc       = '0;
    bus.in_rs1_data = '0;
    bus.in_rs2_data = '0;
    bus.out_ready   = 1'b0;
    @(negedge clk);
    do_reset();

    vecs[0]  = '{"add",     32'h002081B3, 32'h0,   32'd5,  32'd7, 32'd5,   32'd7,        4'd0,  1'b0, 1'b0};
    vecs[1]  = '{"sub",     32'h402081B3, 32'h0,   32'd5,  32'd7, 32'd5,   32'd7,        4'd1,  1'b0, 1'b0};
    vecs[2]  = '{"addi",    32'hFFF00093, 32'h0,   32'd10, 32'd0, 32'd10,  32'hFFFFFFFF, 4'd0,  1'b0, 1'b0};
    vecs[3]  = '{"srai",    32'h4050D093, 32'h0,   32'd40, 32'd0, 32'd40,  32'd5,        4'd7,  1'b0, 1'b0};
    vecs[4]  = '{"bge",     32'h0020D463, 32'h0,   32'd3,  32'd9, 32'd3,   32'd9,        4'd12, 1'b1, 1'b0};
    vecs[5]  = '{"lui",     32'h123452B7, 32'h0,   32'd1,  32'd2, 32'd0,   32'h12345000, 4'd0,  1'b0, 1'b0};
    vecs[6]  = '{"custom0", 32'h0000000B, 32'h40,  32'd1,  32'd2, 32'd0,   32'd0,        4'd0,  1'b0, 1'b1};
    vecs[7]  = '{"f7bad",   32'h0200D0B3, 32'h40,  32'd1,  32'd2, 32'd0,   32'd0,        4'd0,  1'b0, 1'b1};
    vecs[8]  = '{"auipc",   32'h00001117, 32'h100, 32'd1,  32'd2, 32'h100, 32'h1000,     4'd0,  1'b0, 1'b0};
    vecs[9]  = '{"jal",     32'h0000006F, 32'h200, 32'd1,  32'd2, 32'h200, 32'd4,        4'd0,  1'b0, 1'b0};
    vecs[10] = '{"sw",      32'h0020A223, 32'h0,   32'd64, 32'd2, 32'd64,  32'd4,        4'd0,  1'b0, 1'b0};
    vecs[11] = '{"lw",      32'hFFC0A103, 32'h0,   32'd64, 32'd2, 32'd64,  32'hFFFFFFFC, 4'd0,  1'b0, 1'b0};
    vecs[12] = '{"br010",   32'h0020A463, 32'h0,   32'd3,  32'd9, 32'd0,   32'd0,        4'd0,  1'b0, 1'b1};
    vecs[13] = '{"slli_f7", 32'h40109093, 32'h0,   32'd3,  32'd9, 32'd0,   32'd0,        4'd0,  1'b0, 1'b1};
    vecs[14] = '{"low2bit", 32'h00000032, 32'h0,   32'd3,  32'd9, 32'd0,   32'd0,        4'd0,  1'b0, 1'b1};

    foreach (vecs[i]) begin
      step(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].r1, vecs[i].r2, 1'b1, acc);
      chk({vecs[i].name, " accepted"}, 32'(acc), 32'd1);
      chk({vecs[i].name, " out_valid"}, 32'(bus.out_valid),   32'd1);
      chk({vecs[i].name, " alu_a"},   bus.out_alu_a,          vecs[i].a);
      chk({vecs[i].name, " alu_b"},   bus.out_alu_b,          vecs[i].b);
      chk({vecs[i].name, " ctrl"},    32'(bus.out_alu_ctrl),  32'(vecs[i].ctrl));
      chk({vecs[i].name, " branch"},  32'(bus.out_branch),    32'(vecs[i].br));
      chk({vecs[i].name, " illegal"}, 32'(bus.out_illegal),   32'(vecs[i].ill));
      $display("vec %-8s instr=%08h a=%08h b=%08h ctrl=%0d br=%0d ill=%0d",
               vecs[i].name, vecs[i].instr, bus.out_alu_a, bus.out_alu_b,
               bus.out_alu_ctrl, bus.out_branch, bus.out_illegal);
    end
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, acc);

    // Stall: offer distinct addi beats with out_ready low; only two may enter.
    n = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 32'h00000093, 32'h0, 32'h1000 + 32'(n), 32'h0, 1'b0, acc);
      if (acc) n++;
      chk("stall hold alu_a", bus.out_alu_a, 32'h1000);
    end
    chk("stall accepted", 32'(n), 32'd2);
    $display("stall accepted=%0d in_ready=%0d", n, bus.in_ready);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, acc);
    chk("drain second alu_a", bus.out_alu_a, 32'h1001);
    chk("drain no gap", 32'(bus.out_valid), 32'd1);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, acc);
    chk("drain empty", 32'(bus.out_valid), 32'd0);

    // Reset while both entries are full, then one fresh beat must come out alone.
    step(1'b1, 32'h00000093, 32'h0, 32'hAAAA0001, 32'h0, 1'b0, acc);
    step(1'b1, 32'h00000093, 32'h0, 32'hAAAA0002, 32'h0, 1'b0, acc);
    chk("midstall full", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    do_reset();
    step(1'b1, 32'h00000093, 32'h0, 32'hBBBB0001, 32'h0, 1'b1, acc);
    chk("post-rst beat", bus.out_alu_a, 32'hBBBB0001);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, acc);
    chk("post-rst alone", 32'(bus.out_valid), 32'd0);
    $display("midstall reset flushed, single beat observed");

    // Randomised stream against the queue model; a beat is held until accepted.
    n = 0;
    cyc = 0;
    cur_v = 1'b0;
    cur_ins = rand_instr(); cur_pc = $urandom(); cur_r1 = $urandom(); cur_r2 = $urandom();
    while (n < 1000 && cyc < 20000) begin
      if (!cur_v) cur_v = ($urandom_range(0, 4) != 0);
      step(cur_v, cur_ins, cur_pc, cur_r1, cur_r2, 1'($urandom_range(0, 1)), acc);
      if (acc) begin
        n++;
        cur_v = 1'b0;
        cur_ins = rand_instr(); cur_pc = $urandom(); cur_r1 = $urandom(); cur_r2 = $urandom();
      end
      cyc++;
    end
    chk("random beats accepted", 32'(n), 32'd1000);
    cyc = 0;
    while (q.size() > 0 && cyc < 10) begin
      step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, acc);
      cyc++;
    end
    chk("random drained", 32'(q.size()), 32'd0);
    $display("random stream beats=%0d", n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
